// File: rtl/ltc2195_tx_emulator.sv
// LTC2195-style 2-lane serial transmitter: 2-deep sample FIFO feeding an 8-slot
// framed serializer (DCO, FR, D0/D1 lanes) with underflow and frame accounting.
module ltc2195_tx_emulator #(
    parameter logic [15:0] TP                = 16'hA5C3,
    parameter bit          HOLD_ON_UNDERFLOW = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        run_in,
    input  logic        tp_en_in,
    input  logic        s_valid_in,
    output logic        s_ready_out,
    input  logic [15:0] s_ch0_in,
    input  logic [15:0] s_ch1_in,
    output logic        DCO_out,
    output logic        FR_out,
    output logic [1:0]  D0_out,
    output logic [1:0]  D1_out,
    output logic        underflow_out,
    output logic [7:0]  underflow_cnt_out,
    output logic [15:0] frame_cnt_out
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic [31:0] word_q, word_d;
    logic [31:0] last_q, last_d;
    logic        uf_q, uf_d;
    logic [7:0]  ufcnt_q, ufcnt_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        dco_q, dco_d;
    logic        fr_q, fr_d;
    logic [1:0]  d0_q, d0_d;
    logic [1:0]  d1_q, d1_d;

    logic [31:0] mem_q [2];
    logic        wr_q, rd_q;
    logic [1:0]  cnt_q;
    logic        full, push, pop, load;
    logic [3:0]  bit_odd, bit_even;

    assign full        = (cnt_q == 2'd2);
    assign s_ready_out = !full;
    assign push        = s_valid_in && !full;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        word_d   = word_q;
        last_d   = last_q;
        uf_d     = uf_q;
        ufcnt_d  = ufcnt_q;
        fcnt_d   = fcnt_q;
        load     = 1'b0;
        pop      = 1'b0;
        dco_d    = 1'b0;
        fr_d     = 1'b0;
        d0_d     = '0;
        d1_d     = '0;
        bit_odd  = '0;
        bit_even = '0;

        case (state_q)
            IDLE: begin
                slot_d = 3'd7;
                if (run_in) begin
                    load    = 1'b1;
                    state_d = RUN;
                    slot_d  = 3'd0;
                end
            end
            RUN: begin
                if (slot_q == 3'd7) begin
                    if (run_in) begin
                        load   = 1'b1;
                        slot_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                        slot_d  = 3'd7;
                    end
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            fcnt_d = fcnt_q + 16'd1;
            if (tp_en_in) begin
                word_d = {TP, TP};
            end else if (cnt_q != 2'd0) begin
                pop    = 1'b1;
                word_d = mem_q[rd_q];
                last_d = mem_q[rd_q];
            end else begin
                uf_d    = 1'b1;
                ufcnt_d = (ufcnt_q == 8'hFF) ? ufcnt_q : ufcnt_q + 8'd1;
                word_d  = HOLD_ON_UNDERFLOW ? last_q : '0;
            end
        end

        // Output registers are fed from the next slot so slot 0 lands the cycle after a load.
        if (state_d == RUN) begin
            bit_odd  = 4'd15 - {slot_d, 1'b0};
            bit_even = 4'd14 - {slot_d, 1'b0};
            fr_d     = ~slot_d[2];
            dco_d    = ~slot_d[0];
            d0_d     = {word_d[16 + 32'(bit_even)], word_d[16 + 32'(bit_odd)]};
            d1_d     = {word_d[bit_even], word_d[bit_odd]};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            slot_q  <= 3'd7;
            word_q  <= '0;
            last_q  <= '0;
            uf_q    <= 1'b0;
            ufcnt_q <= '0;
            fcnt_q  <= '0;
            dco_q   <= 1'b0;
            fr_q    <= 1'b0;
            d0_q    <= '0;
            d1_q    <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            word_q  <= word_d;
            last_q  <= last_d;
            uf_q    <= uf_d;
            ufcnt_q <= ufcnt_d;
            fcnt_q  <= fcnt_d;
            dco_q   <= dco_d;
            fr_q    <= fr_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= {s_ch0_in, s_ch1_in};
                wr_q        <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

    assign DCO_out           = dco_q;
    assign FR_out            = fr_q;
    assign D0_out            = d0_q;
    assign D1_out            = d1_q;
    assign underflow_out     = uf_q;
    assign underflow_cnt_out = ufcnt_q;
    assign frame_cnt_out     = fcnt_q;

endmodule
